// File: rtl/sync_fifo_if.sv
// sync_fifo_if -- handshake and status bundle for sync_fifo.
//
// Signals:
//   W_INC, WR_DATA          write request and write word (master -> slave)
//   R_INC                   read request (master -> slave)
//   RD_DATA, RD_VALID       read word and its valid qualifier (slave -> master)
//   FULL, EMPTY             occupancy == DEPTH / occupancy == 0
//   ALMOST_FULL/EMPTY       threshold flags
//   OVERFLOW, UNDERFLOW     sticky error flags
//   COUNT                   current occupancy, 0..DEPTH
//
// Modports: master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) ();
    logic                  W_INC;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  R_INC;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_VALID;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;
    logic [ADDR_WIDTH:0]   COUNT;

    modport master (
        output W_INC, WR_DATA, R_INC,
        input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               OVERFLOW, UNDERFLOW, COUNT
    );

    modport slave (
        input  W_INC, WR_DATA, R_INC,
        output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               OVERFLOW, UNDERFLOW, COUNT
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with registered occupancy count, threshold
// flags, sticky overflow/underflow flags and a selectable read mode.
//
// Ports:
//   CLK   sole clock, all state updates on the rising edge
//   RST   synchronous active-high reset
//   bus   sync_fifo_if.slave: W_INC/WR_DATA/R_INC in; RD_DATA, RD_VALID,
//         FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW, COUNT out
//
// Parameters: DATA_WIDTH, ADDR_WIDTH (DEPTH = 2**ADDR_WIDTH), AF_LEVEL,
// AE_LEVEL, FWFT (0 = registered read, 1 = first-word-fall-through).
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic        CLK,
    input  logic        RST,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  full, empty;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    // Status flags come from the registered count only, so no request input
    // has a combinational path to them.
    always_comb begin
        full    = (count_q == DEPTH_CNT);
        empty   = (count_q == '0);
        wr_acc  = bus.W_INC && !full;
        rd_acc  = bus.R_INC && !empty;
        wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
        rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    end

    // Next-state for pointers, count, read register and error flags.
    // Pointers carry an extra wrap bit; only the low bits address storage,
    // so rolling over from DEPTH-1 to 0 needs no special handling.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_d    = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        count_d     = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        rd_data_d   = rd_acc ? mem_q[rd_addr] : rd_data_q;
        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q  || (bus.W_INC && full);
        underflow_d = underflow_q || (bus.R_INC && empty);
    end

    // Control state with synchronous reset; reset wins over any request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; after reset the pointers make old words
    // unreachable. Read and write can only share an address when the FIFO
    // is full or empty, and then one of them is rejected, so no forwarding.
    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) begin
            mem_q[wr_addr] <= bus.WR_DATA;
        end
    end

    // In fall-through mode the head word is shown directly from storage and
    // is valid whenever the FIFO holds anything.
    always_comb begin
        bus.RD_DATA      = (FWFT != 0) ? mem_q[rd_addr] : rd_data_q;
        bus.RD_VALID     = (FWFT != 0) ? !empty : rd_valid_q;
        bus.FULL         = full;
        bus.EMPTY        = empty;
        bus.ALMOST_FULL  = (count_q >= AF_CNT);
        bus.ALMOST_EMPTY = (count_q <= AE_CNT);
        bus.OVERFLOW     = overflow_q;
        bus.UNDERFLOW    = underflow_q;
        bus.COUNT        = count_q;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo -- self-checking bench for sync_fifo.
// Two instances share one stimulus stream: dut0 in registered-read mode and
// dut1 in fall-through mode. A queue-based reference model tracks contents,
// sticky flags and the expected registered read word.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL),
                .AE_LEVEL(AEL), .FWFT(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL),
                .AE_LEVEL(AEL), .FWFT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    always #5 CLK = ~CLK;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [DW-1:0] modelQ[$];
    bit            modelOvf = 0;
    bit            modelUnf = 0;
    logic [DW-1:0] modelRdData = '0;
    bit            modelRdValid = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the pre-edge occupancy.
    task automatic updateModel(input bit w, input bit r, input logic [DW-1:0] d, input bit rst);
        bit isFull;
        bit isEmpty;
        if (rst) begin
            modelQ.delete();
            modelOvf     = 0;
            modelUnf     = 0;
            modelRdData  = '0;
            modelRdValid = 0;
        end else begin
            isFull  = (modelQ.size() == DEPTH);
            isEmpty = (modelQ.size() == 0);
            if (w && isFull)  modelOvf = 1;
            if (r && isEmpty) modelUnf = 1;
            if (r && !isEmpty) begin
                modelRdData  = modelQ.pop_front();
                modelRdValid = 1;
            end else begin
                modelRdValid = 0;
            end
            if (w && !isFull) modelQ.push_back(d);
        end
    endtask

    task automatic checkAll();
        int n;
        n = modelQ.size();
        checkOutput("count0",    int'(bus0.COUNT),        n);
        checkOutput("full0",     int'(bus0.FULL),         int'(n == DEPTH));
        checkOutput("empty0",    int'(bus0.EMPTY),        int'(n == 0));
        checkOutput("afull0",    int'(bus0.ALMOST_FULL),  int'(n >= AFL));
        checkOutput("aempty0",   int'(bus0.ALMOST_EMPTY), int'(n <= AEL));
        checkOutput("ovf0",      int'(bus0.OVERFLOW),     int'(modelOvf));
        checkOutput("unf0",      int'(bus0.UNDERFLOW),    int'(modelUnf));
        checkOutput("rdvalid0",  int'(bus0.RD_VALID),     int'(modelRdValid));
        checkOutput("rddata0",   int'(bus0.RD_DATA),      int'(modelRdData));
        checkOutput("count1",    int'(bus1.COUNT),        n);
        checkOutput("ovf1",      int'(bus1.OVERFLOW),     int'(modelOvf));
        checkOutput("unf1",      int'(bus1.UNDERFLOW),    int'(modelUnf));
        checkOutput("rdvalid1",  int'(bus1.RD_VALID),     int'(n != 0));
        if (n != 0) begin
            checkOutput("rddata1", int'(bus1.RD_DATA), int'(modelQ[0]));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic applyStimulus(input bit w, input bit r, input logic [DW-1:0] d, input bit rst);
        bus0.W_INC   = w;
        bus0.R_INC   = r;
        bus0.WR_DATA = d;
        bus1.W_INC   = w;
        bus1.R_INC   = r;
        bus1.WR_DATA = d;
        RST          = rst;
        @(posedge CLK);
        updateModel(w, r, d, rst);
        #1;
        checkAll();
    endtask

    initial begin
        bus0.W_INC = 0; bus0.R_INC = 0; bus0.WR_DATA = '0;
        bus1.W_INC = 0; bus1.R_INC = 0; bus1.WR_DATA = '0;
        #2;

        // Reset state
        applyStimulus(0, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 1);

        // Fill with 0x01..0x08, then a rejected 9th write
        for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 8'(i), 0);
        applyStimulus(1, 0, 8'hAA, 0);
        applyStimulus(0, 0, 8'h00, 0);

        // Drain in order, then idle to see RD_VALID drop and data hold
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);

        // Read while empty
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);

        // Wrap test: occupancy 4, then 12 simultaneous write/read pairs
        applyStimulus(0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'(8'h10 + i), 0);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'h00, 0);

        // Full with both requests: read accepted, write rejected
        applyStimulus(0, 0, 8'h00, 1);
        for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 8'(i), 0);
        applyStimulus(1, 1, 8'hEE, 0);

        // Empty with both requests: write accepted, read rejected
        applyStimulus(0, 0, 8'h00, 1);
        applyStimulus(1, 1, 8'h5A, 0);
        applyStimulus(0, 0, 8'h00, 0);

        // Fall-through word after a write into an empty FIFO
        applyStimulus(0, 0, 8'h00, 1);
        applyStimulus(1, 0, 8'h5A, 0);
        applyStimulus(0, 1, 8'h00, 0);

        // Reset overriding a write at occupancy 5
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'(8'h20 + i), 0);
        applyStimulus(1, 0, 8'hCC, 1);
        applyStimulus(0, 0, 8'h00, 0);

        // Randomized traffic: write-heavy, then read-heavy, rare resets
        for (int i = 0; i < 600; i++) begin
            bit w;
            bit r;
            bit rst;
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus(w, r, 8'($urandom), rst);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter AF_LEVEL, default 6, ALMOST_FULL assert threshold (1..DEPTH-1).
REQ-004 Parameter AE_LEVEL, default 2, ALMOST_EMPTY assert threshold (1..DEPTH-1).
REQ-005 Parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset: CLK (in, 1) and RST (in, 1); there is no other clock or reset.
REQ-007 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-008 RST  in  1  synchronous active-high reset.
REQ-009 W_INC  in  1  write request.
REQ-010 WR_DATA  in  DATA_WIDTH  write word.
REQ-011 R_INC  in  1  read request.
REQ-012 RD_DATA  out  DATA_WIDTH  read word.
REQ-013 RD_VALID  out  1  RD_DATA holds a valid word.
REQ-014 FULL, EMPTY  out  1 each  occupancy == DEPTH, occupancy == 0.
REQ-015 ALMOST_FULL, ALMOST_EMPTY  out  1 each  threshold flags.
REQ-016 OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.
REQ-017 COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_WIDTH array, written only on an accepted write.
REQ-019 Pointers SHALL be ADDR_WIDTH+1 bits, with the MSB used as the wrap bit; the address is the low ADDR_WIDTH bits; wrap DEPTH-1 -> 0 is silent.
REQ-020 Write accepted iff W_INC && !FULL, with FULL sampled before the edge; an accepted write stores WR_DATA at wr_ptr, then wr_ptr+1.
REQ-021 Read accepted iff R_INC && !EMPTY, with EMPTY sampled before the edge; an accepted read advances rd_ptr+1.
REQ-022 COUNT SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 Simultaneous accepted read and write SHALL be legal at any occupancy 1..DEPTH-1; COUNT and all flags are unchanged.
REQ-024 When full, W_INC && R_INC SHALL accept the read, reject the write, and set OVERFLOW; COUNT becomes DEPTH-1.
REQ-025 When empty, W_INC && R_INC SHALL accept the write, reject the read, and set UNDERFLOW; no bypass, COUNT becomes 1.
REQ-026 FULL, EMPTY, ALMOST_FULL (COUNT >= AF_LEVEL) and ALMOST_EMPTY (COUNT <= AE_LEVEL) SHALL be decoded from registered COUNT only, with no combinational path from W_INC or R_INC.
REQ-027 OVERFLOW SHALL set on W_INC && FULL, UNDERFLOW SHALL set on R_INC && EMPTY; both stay set until RST.
REQ-028 FWFT=0: an accepted read SHALL register mem[rd_addr] into RD_DATA with RD_VALID=1 the following cycle (latency 1); RD_VALID=0 in cycles after no accepted read; RD_DATA holds its last value.
REQ-029 FWFT=1: RD_DATA SHALL equal mem[rd_addr] whenever !EMPTY, RD_VALID = !EMPTY; R_INC pops the shown word (latency 0); a word written into an empty FIFO appears the cycle after the write.
REQ-030 Read-during-write to the same address SHALL be impossible by construction (only when full/empty); no forwarding is needed.

Reset
REQ-031 RST sampled high at an edge SHALL clear wr_ptr, rd_ptr, COUNT, RD_DATA, RD_VALID, OVERFLOW and UNDERFLOW to 0, giving EMPTY=1, ALMOST_EMPTY=1, FULL=0 and ALMOST_FULL=0.
REQ-032 RST SHALL override W_INC and R_INC in the same cycle; memory contents are not cleared and are unreachable after reset.
REQ-033 RST asserted mid-operation (any COUNT) SHALL discard all content within one edge.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 Reset, then write 0x01..0x08 -> COUNT steps 1..8, ALMOST_EMPTY drops at COUNT=3, ALMOST_FULL rises at COUNT=6, FULL=1 at 8, OVERFLOW=0.
REQ-035 Full, 9th write of 0xAA -> OVERFLOW=1 sticky, COUNT=8, subsequent reads return 0x01..0x08 in order (FWFT=0 each one cycle after R_INC), then EMPTY=1.
REQ-036 Empty, R_INC for one cycle -> UNDERFLOW=1, COUNT=0, RD_VALID stays 0.
REQ-037 12 write/read pairs at COUNT=4 -> pointers wrap, COUNT stays 4, data order preserved across the wrap.
REQ-038 Full, W_INC and R_INC together -> read data 0x01, write rejected, OVERFLOW=1, COUNT=7; with FWFT=1, write 0x5A into an empty FIFO -> next cycle RD_VALID=1, RD_DATA=0x5A.
REQ-039 COUNT=5 with W_INC and RST high together -> next cycle COUNT=0, EMPTY=1, flags cleared.
